// File: rtl/sys_defs_pkg.sv
// Shared system definitions: XLEN, ZERO_REG, ROB entry and commit FSM states.
// Consumers see the macros through the guarded defines below.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ZERO_REG
`define ZERO_REG 5'd0
`endif

package sys_defs_pkg;

    typedef struct packed {
        logic              valid;
        logic              wr_mem;
        logic [4:0]        dest_reg;
        logic [`XLEN-1:0]  value;
        logic [`XLEN-1:0]  dest_addr;
    } ROB_ENTRY;

    typedef enum logic {
        IDLE,
        STORE_WAIT
    } commit_state_t;

endpackage

// File: rtl/commit_unit.sv
// In-order commit stage: retires the ROB head, writes the RF, issues stores.
// Optional statistics counters are built when COMMIT_STATS_EN is defined.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ZERO_REG
`define ZERO_REG 5'd0
`endif

module commit_unit
    import sys_defs_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 head_ready,
    input  ROB_ENTRY             head_entry,
    input  logic                 mem_ack,
    output logic                 retire,
    output logic                 rf_we,
    output logic [4:0]           rf_dest,
    output logic [`XLEN-1:0]     rf_value,
    output logic                 mem_req,
    output logic [`XLEN-1:0]     mem_addr,
    output logic [`XLEN-1:0]     mem_data,
    output logic                 busy
`ifdef COMMIT_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] retired_count,
    output logic [CNT_WIDTH-1:0] store_count
`endif
);

    commit_state_t state, next_state;
    logic          accept;
    logic          rf_wr;
    logic          st_issue;
    logic          st_done;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        retire     = 1'b0;
        st_done    = 1'b0;
        unique case (state)
            IDLE: begin
                accept = head_ready && head_entry.valid;
                retire = accept && !head_entry.wr_mem;
                if (accept && head_entry.wr_mem) begin
                    next_state = STORE_WAIT;
                end
            end
            STORE_WAIT: begin
                st_done = mem_ack;
                retire  = mem_ack;
                if (mem_ack) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (reset) begin
            retire  = 1'b0;
            st_done = 1'b0;
        end
    end

    assign busy     = (state == STORE_WAIT);
    assign st_issue = accept && head_entry.wr_mem;
    assign rf_wr    = accept && !head_entry.wr_mem &&
                      (head_entry.dest_reg != `ZERO_REG);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_dest  <= '0;
            rf_value <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            rf_we <= rf_wr;
            if (rf_wr) begin
                rf_dest  <= head_entry.dest_reg;
                rf_value <= head_entry.value;
            end
            // Address/data are only loaded on issue, so they hold through the wait.
            if (st_issue) begin
                mem_req  <= 1'b1;
                mem_addr <= head_entry.dest_addr;
                mem_data <= head_entry.value;
            end else if (st_done) begin
                mem_req  <= 1'b0;
            end
        end
    end

`ifdef COMMIT_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retired_count <= '0;
            store_count   <= '0;
        end else begin
            if (retire) begin
                retired_count <= retired_count + 1'b1;
            end
            if (st_done) begin
                store_count <= store_count + 1'b1;
            end
        end
    end
`endif

endmodule
